// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter/sequencer letting two requesters share one single-port memory.
// Each transaction takes exactly three cycles: IDLE (grant) -> ACCESS -> DONE (ack).
module mem_arbiter #(
   parameter int DATA_W     = 32,
   parameter int DEPTH_LOG2 = 8
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_req0,
   input  logic              i_we0,
   input  logic [DATA_W-1:0] i_addr0,
   input  logic [DATA_W-1:0] i_wdata0,
   output logic              o_ack0,
   output logic              o_err0,
   input  logic              i_req1,
   input  logic              i_we1,
   input  logic [DATA_W-1:0] i_addr1,
   input  logic [DATA_W-1:0] i_wdata1,
   output logic              o_ack1,
   output logic              o_err1,
   output logic [DATA_W-1:0] o_rdata,
   output logic [DATA_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_in,
   output logic              o_mem_wr,
   input  logic [DATA_W-1:0] i_mem_out,
   output logic              o_busy,
   output logic              o_gnt_id
);
   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

   state_t            r_state, w_next;
   logic              r_last_gnt, r_gnt, r_we, r_in_range, r_mem_wr;
   logic [DATA_W-1:0] r_mem_addr, r_mem_in, r_rdata;
   logic              w_grant, w_sel, w_we, w_in_range, w_done;
   logic [DATA_W-1:0] w_addr, w_wdata;

   always_comb begin
      w_next     = r_state;
      w_sel      = (i_req0 & i_req1) ? ~r_last_gnt : i_req1;
      w_grant    = (r_state == S_IDLE) & (i_req0 | i_req1);
      w_we       = w_sel ? i_we1 : i_we0;
      w_addr     = w_sel ? i_addr1 : i_addr0;
      w_wdata    = w_sel ? i_wdata1 : i_wdata0;
      w_in_range = (w_addr[DATA_W-1:DEPTH_LOG2] == '0);
      case (r_state)
         S_IDLE:   w_next = w_grant ? S_ACCESS : S_IDLE;
         S_ACCESS: w_next = S_DONE;
         default:  w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state    <= S_IDLE;
         r_last_gnt <= 1'b1;
         r_gnt      <= 1'b0;
         r_we       <= 1'b0;
         r_in_range <= 1'b1;
         r_mem_wr   <= 1'b0;
         r_mem_addr <= '0;
         r_mem_in   <= '0;
         r_rdata    <= '0;
      end else begin
         r_state <= w_next;
         if (w_grant) begin
            r_gnt      <= w_sel;
            r_last_gnt <= w_sel;
            r_we       <= w_we;
            r_in_range <= w_in_range;
            r_mem_addr <= w_addr;
            r_mem_in   <= w_wdata;
            r_mem_wr   <= w_we & w_in_range;
         end
         // memory performs the write on this edge; read data is captured on it too
         if (r_state == S_ACCESS) begin
            r_mem_wr <= 1'b0;
            if (!r_we) r_rdata <= r_in_range ? i_mem_out : '0;
         end
      end
   end

   assign w_done     = (r_state == S_DONE);
   assign o_ack0     = w_done & ~r_gnt;
   assign o_ack1     = w_done & r_gnt;
   assign o_err0     = o_ack0 & ~r_in_range;
   assign o_err1     = o_ack1 & ~r_in_range;
   assign o_rdata    = r_rdata;
   assign o_mem_addr = r_mem_addr;
   assign o_mem_in   = r_mem_in;
   assign o_mem_wr   = r_mem_wr;
   assign o_busy     = (r_state != S_IDLE);
   assign o_gnt_id   = r_gnt;
endmodule
